// File: rtl/rotate_finder_pkg.sv
// rotate_finder_pkg: shared FSM states, default width and single-bit rotate helper.
package rotate_finder_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  localparam int DEFAULT_WIDTH = 16;
  function automatic logic [63:0] rotate_one(input logic [63:0] a, input int w, input logic left);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++)
      if (i < w) y[6'(i)] = left ? a[6'((i + w - 1) % w)] : a[6'((i + 1) % w)];
    return y;
  endfunction
endpackage

// File: rtl/rotate_finder_step.sv
// rotate_step: combinational one-bit rotation of a WIDTH-bit word.
module rotate_step import rotate_finder_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic             left,
  output logic [WIDTH-1:0] y
);
  assign y = WIDTH'(rotate_one(64'(a), WIDTH, left));
endmodule

// File: rtl/rotate_finder.sv
// rotate_finder: finds the smallest rotation of data_in that equals pattern.
module rotate_finder import rotate_finder_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     left,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [WIDTH-1:0]         pattern,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [$clog2(WIDTH)-1:0] amount,
  output logic [WIDTH-1:0]         aligned
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] work, pat, work_rot;
  logic [CW-1:0] cnt;
  logic dir, hit, last;
  rotate_step #(.WIDTH(WIDTH)) u_step (.a(work), .left(dir), .y(work_rot));
  assign hit = work == pat;
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state == IDLE ? (start ? SEARCH : IDLE) :
              state == SEARCH ? (hit || last ? DONE : SEARCH) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work <= '0;
      pat <= '0;
      dir <= 1'b0;
      cnt <= '0;
      found <= 1'b0;
      amount <= '0;
      aligned <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        work <= data_in;
        pat <= pattern;
        dir <= left;
        cnt <= '0;
      end
      if (state == SEARCH) begin
        if (hit || last) begin
          found <= hit;
          amount <= hit ? cnt : '0;
          aligned <= work;
        end else begin
          work <= work_rot;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rotate_finder.sv
// tb_rotate_finder: directed self-checking bench for rotate_finder (WIDTH=16).
module tb_rotate_finder;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst, start, left;
  logic [W-1:0] data_in, pattern, aligned;
  logic busy, done, found;
  logic [3:0] amount;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rotate_finder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .left(left), .data_in(data_in),
    .pattern(pattern), .busy(busy), .done(done), .found(found),
    .amount(amount), .aligned(aligned)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(output int n, output int b);
    n = 0;
    b = int'(busy);
    while (!done && n < 40) begin
      tick;
      n++;
      b += int'(busy);
    end
  endtask
  task automatic run(input string tag, input logic [W-1:0] d, input logic [W-1:0] p,
                     input logic l, input int lat, input logic f, input logic [3:0] amt,
                     input logic [W-1:0] al);
    int n, b;
    data_in = d;
    pattern = p;
    left = l;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(n, b);
    chk({tag, " latency"}, n, lat);
    chk({tag, " found"}, found, f);
    chk({tag, " amount"}, amount, amt);
    chk({tag, " aligned"}, aligned, al);
    chk({tag, " busy cycles"}, b, lat + 1);
    tick;
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " idle"}, busy, 0);
  endtask
  initial begin
    int n, b, seen;
    rst = 1'b1;
    start = 1'b1;
    left = 1'b1;
    data_in = 16'h1234;
    pattern = 16'h1234;
    tick;
    tick;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset found", found, 0);
    chk("reset amount", amount, 0);
    chk("reset aligned", aligned, 0);
    rst = 1'b0;
    start = 1'b0;
    tick;
    run("left k1", 16'hACF1, 16'h59E3, 1'b1, 2, 1'b1, 4'd1, 16'h59E3);
    run("right k2", 16'hACF1, 16'h6B3C, 1'b0, 3, 1'b1, 4'd2, 16'h6B3C);
    run("left k4", 16'hACF1, 16'hCF1A, 1'b1, 5, 1'b1, 4'd4, 16'hCF1A);
    run("periodic k0", 16'hAAAA, 16'hAAAA, 1'b1, 1, 1'b1, 4'd0, 16'hAAAA);
    run("periodic k1", 16'hAAAA, 16'h5555, 1'b1, 2, 1'b1, 4'd1, 16'h5555);
    run("no match", 16'hACF1, 16'h0000, 1'b1, 16, 1'b0, 4'd0, 16'hD678);
    run("right k15", 16'hACF1, 16'h59E3, 1'b0, 16, 1'b1, 4'd15, 16'h59E3);
    tick;
    tick;
    chk("hold found", found, 1);
    chk("hold amount", amount, 15);
    chk("hold aligned", aligned, 16'h59E3);
    data_in = 16'hACF1;
    pattern = 16'hCF1A;
    left = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    start = 1'b1;
    data_in = 16'hAAAA;
    pattern = 16'hAAAA;
    left = 1'b0;
    tick;
    start = 1'b0;
    wait_done(n, b);
    chk("ignore start latency", n + 2, 5);
    chk("ignore start amount", amount, 4);
    chk("ignore start aligned", aligned, 16'hCF1A);
    tick;
    tick;
    chk("ignore start no rerun", busy, 0);
    left = 1'b1;
    data_in = 16'hACF1;
    pattern = 16'h0000;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    rst = 1'b1;
    start = 1'b1;
    tick;
    rst = 1'b0;
    start = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort found", found, 0);
    chk("abort amount", amount, 0);
    chk("abort aligned", aligned, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      seen += int'(done) + int'(busy);
    end
    chk("abort no done", seen, 0);
    run("after abort", 16'hAAAA, 16'h5555, 1'b1, 2, 1'b1, 4'd1, 16'h5555);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rotate_finder.md
ROTATE_FINDER -- requirements
Module: rotate_finder

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data and pattern word width; WIDTH is a power of two, 4..64.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a search; sampled only in IDLE.
REQ-005 SHALL have port: left  input  1  1 = search left rotations, y={a[W-2:0],a[W-1]}; 0 = right rotations, y={a[0],a[W-1:1]}.
REQ-006 SHALL have port: data_in  input  WIDTH  word to be aligned; captured on an accepted start.
REQ-007 SHALL have port: pattern  input  WIDTH  target word; captured on an accepted start.
REQ-008 SHALL have port: busy  output  1  high in SEARCH and DONE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse on search completion.
REQ-010 SHALL have port: found  output  1  result valid flag: a rotation matched.
REQ-011 SHALL have port: amount  output  log2(WIDTH)  smallest rotation count k with rot^k(data_in, left) == pattern; 0 when not found.
REQ-012 SHALL have port: aligned  output  WIDTH  rotated word at termination (== pattern when found; rot^(WIDTH-1)(data_in) when not).

Function
REQ-013 SHALL implement FSM states IDLE, SEARCH, DONE.
REQ-014 IDLE: start=1 SHALL capture data_in into work register, pattern and left into holding registers, clear counter to 0, go SEARCH.
REQ-015 SEARCH, each cycle: work==pattern SHALL register found=1, amount=counter, aligned=work, go DONE.
REQ-016 SEARCH, no match and counter==WIDTH-1: SHALL register found=0, amount=0, aligned=work, go DONE.
REQ-017 SEARCH, otherwise: SHALL rotate work by one bit in captured direction and increment counter.
REQ-018 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally.
REQ-019 Latency: match at count k SHALL put done high in the (k+1)th cycle after the start-accepting edge; no match SHALL take WIDTH cycles.
REQ-020 start during SEARCH or DONE SHALL be ignored; input changes after capture SHALL not affect the running search.
REQ-021 Periodic words (e.g. 16'hAAAA) SHALL report the smallest matching k.
REQ-022 found, amount, aligned SHALL hold their values from done until the next done or reset.
REQ-023 left changes outside capture SHALL have no effect.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, found=0, amount=0, aligned=0, counter=0, work=0.
REQ-025 rst during SEARCH SHALL abort the search with no done pulse; rst SHALL take priority over start.

Structure
REQ-026 A shared package SHALL hold the FSM state enumeration, default WIDTH, and a rotate-by-one function parameterised on direction.
REQ-027 One sub-module rotate_step (combinational single-bit rotator, WIDTH and left inputs) SHALL be instantiated for the work-register next value.

Verification
REQ-028 data_in=16'hACF1, pattern=16'h59E3, left=1 -> done 2 cycles after start, found=1, amount=1, aligned=16'h59E3.
REQ-029 data_in=16'hACF1, pattern=16'h6B3C, left=0 -> done 3 cycles after start, found=1, amount=2; same data with pattern=16'hCF1A, left=1 -> amount=4.
REQ-030 data_in=pattern=16'hAAAA, left=1 -> done 1 cycle after start, found=1, amount=0; pattern=16'h5555 -> amount=1.
REQ-031 data_in=16'hACF1, pattern=16'h0000 -> done 16 cycles after start, found=0, amount=0, busy high for 17 cycles.
REQ-032 start pulsed again mid-search with different data -> ignored, first result unchanged; rst asserted at count 5 -> no done, all outputs 0, next start runs normally.
